preadd_op_sequencer: RTL
========================

Name: preadd_op_sequencer

Overview:
- Issue controller for the dual A/D pre-adder stage of the DSP48E1 datapath.
- Accepts pre-adder operation requests over a valid/ready handshake and presents A and D to the datapath with per-operand skew, so both meet at the pre-adder in the same cycle.
- Drives INMODE[3:0], CEA1/CEA2/CED/CEAD and RSTA/RSTD, and tags each result with RES_VALID/RES_TAG aligned to A_MULT.
- Sits between the operand source and the pre-adder instance, which is built with A_INPUT="DIRECT" and USE_DPORT="TRUE".

Parameters:
- AREG, 2, A pipeline depth of the controlled datapath (0..2); must match the datapath instance.
- DREG, 1, D pipeline depth (0..1); must match.
- ADREG, 1, AD register depth (0..1); must match.
- TAG_W, 4, width of the request/result tag.

Ports:
- CLK  in  1  clock, shared with the datapath.
- RST_N  in  1  asynchronous active-low reset.
- IN_VALID  in  1  request valid.
- IN_READY  out  1  request accepted when IN_VALID & IN_READY.
- IN_OP  in  3  0 ADD(D+A), 1 SUB(D-A), 2 PASS_A, 3 PASS_D, 4 NEG_A, 5 ZERO, 6/7 reserved.
- IN_A  in  30  A operand.
- IN_D  in  25  D operand.
- IN_TAG  in  TAG_W  request tag.
- HOLD  in  1  freeze the pipeline.
- FLUSH  in  1  discard all in-flight operations.
- DP_A  out  30  to datapath A.
- DP_D  out  25  to datapath D.
- DP_INMODE  out  4  to datapath INMODE_0TO3.
- DP_CEA1, DP_CEA2, DP_CED, DP_CEAD  out  1 each  datapath clock enables.
- DP_RSTA, DP_RSTD  out  1 each  datapath synchronous resets.
- RES_VALID  out  1  A_MULT holds a valid result this cycle.
- RES_TAG  out  TAG_W  tag of that result.
- BUSY  out  1  any operation in flight.
- ERR_OP  out  1  sticky: a reserved opcode was accepted.

Behaviour:
- Alignment latency: L = max(AREG, DREG). Result latency: R = L + ADREG cycles from the accept edge to RES_VALID.
- INMODE[0] is always 0 (A2 path), so A latency = AREG and D latency = DREG.
- Skew registers:
  - DP_A is delayed by L-AREG internal registers after accept.
  - DP_D is delayed by L-DREG internal registers after accept.
  - A zero-latency stage is a wire.
  - On cycles with no accept, the first skew stage loads 0.
- INMODE encoding, decoded at accept and delayed L cycles so it is valid when the operands reach the pre-adder:
  - ADD = 0100.
  - SUB = 1100.
  - PASS_A = 0000.
  - PASS_D = 0110.
  - NEG_A = 1000.
  - ZERO and reserved = 0010.
  - With no op arriving, DP_INMODE = 0010.
- Reserved opcode: accepted, produces a zero result and a normal RES_VALID, and sets ERR_OP. ERR_OP clears only on reset or FLUSH.
- Valid/tag shift register of depth R; RES_VALID/RES_TAG are its last stage. When R = 0, RES_VALID = accept, combinationally.
- Arithmetic is performed by the datapath: 25-bit two's complement, wraps modulo 2^25, only A[24:0] is used. The controller does no arithmetic.
- Throughput is one op per cycle; back-to-back accepts are permitted.
- FSM:
  - RUN:
    - IN_READY = ~HOLD & ~FLUSH.
    - All DP_CE* = ~HOLD.
    - HOLD freezes every internal skew, INMODE and valid/tag register; RES_VALID is forced 0 while HOLD=1, and the stage resumes unchanged afterwards.
  - FLUSH = 1 (any state) -> FLUSHING.
  - FLUSHING (exactly 1 cycle):
    - DP_RSTA = DP_RSTD = 1.
    - All valid bits and skew/INMODE registers are cleared.
    - IN_READY = 0, RES_VALID = 0, ERR_OP cleared.
    - Then RUN, or stay if FLUSH is still 1.
- Priority when signals coincide: FLUSH > HOLD > accept. A request presented with FLUSH=1 is not accepted.
- BUSY = OR of the valid shift bits, or state == FLUSHING.
- Reset (RST_N = 0, asynchronous):
  - State RUN; all internal registers 0.
  - Outputs: IN_READY = 0 while RST_N is low; DP_A = 0, DP_D = 0, DP_INMODE = 0010, DP_CE* = 0, DP_RST* = 1, RES_VALID = 0, RES_TAG = 0, BUSY = 0, ERR_OP = 0.
  - On the first edge after release, DP_RST* = 0 and DP_CE* = 1.
  - Reset mid-operation drops all in-flight ops with no RES_VALID.

Test Plan:
- AREG=2, DREG=1, ADREG=1; accept ADD with A=5, D=7, tag 3 at edge 0 -> DP_D=7 at cycle 1; DP_INMODE=0100 at cycle 2; RES_VALID=1, RES_TAG=3, A_MULT=12 at cycle 3.
- Back-to-back SUB(A=2, D=10), NEG_A(A=1), PASS_D(D=-4) -> A_MULT = 8, -1, -4 on three consecutive RES_VALID cycles with tags in order.
- HOLD raised for 3 cycles with two ops in flight -> IN_READY=0, DP_CE*=0, no RES_VALID during HOLD; both results appear unchanged and in order once HOLD drops.
- FLUSH with 3 ops in flight and IN_VALID=1 -> one cycle DP_RSTA=DP_RSTD=1; no RES_VALID for the flushed ops; the request is not accepted; BUSY=0 after FLUSHING.
- IN_OP=6 with A=9, D=9 -> result 0, RES_VALID asserted, ERR_OP=1 until FLUSH.
- RST_N asserted mid-stream, and the sweep AREG=0/DREG=0/ADREG=0 -> all outputs take reset values immediately; in the zero-latency configuration RES_VALID is combinational with accept.

Source files
------------

// File: rtl/preadd_op_sequencer.sv
// Issue controller for the DSP48E1 dual A/D pre-adder: skews A and D so they meet at the
// pre-adder together, drives INMODE/CE/RST, and tags each result aligned to A_MULT.
module preadd_op_sequencer #(
  parameter int unsigned AREG  = 2,
  parameter int unsigned DREG  = 1,
  parameter int unsigned ADREG = 1,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [29:0]      in_a,
  input  logic [24:0]      in_d,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             hold,
  input  logic             flush,
  output logic [29:0]      dp_a,
  output logic [24:0]      dp_d,
  output logic [3:0]       dp_inmode,
  output logic             dp_cea1,
  output logic             dp_cea2,
  output logic             dp_ced,
  output logic             dp_cead,
  output logic             dp_rsta,
  output logic             dp_rstd,
  output logic             res_valid,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy,
  output logic             err_op
);

  localparam int unsigned A_W    = 30;
  localparam int unsigned D_W    = 25;
  localparam int unsigned IM_W   = 4;
  localparam int unsigned LAT    = (AREG > DREG) ? AREG : DREG;
  localparam int unsigned RLAT   = LAT + ADREG;
  localparam int unsigned A_SKEW = LAT - AREG;
  localparam int unsigned D_SKEW = LAT - DREG;
  localparam logic [IM_W-1:0] IM_IDLE = 4'b0010;

  typedef enum logic {ST_RUN = 1'b0, ST_FLUSHING = 1'b1} state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             reserved;
  logic             ce_en;
  logic             rst_q;
  logic [IM_W-1:0]  im_dec;
  logic [IM_W-1:0]  im_in;
  logic [A_W-1:0]   a_in;
  logic [D_W-1:0]   d_in;
  logic             v_last;
  logic             v_any;
  logic [TAG_W-1:0] t_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_RUN;
    else        state <= next_state;
  end

  // Flush wins over hold, hold wins over accept.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    case (state)
      ST_RUN:      in_ready = rst_n & ~hold & ~flush;
      ST_FLUSHING: if (!flush) next_state = ST_RUN;
      default:     next_state = ST_RUN;
    endcase
    if (flush) next_state = ST_FLUSHING;
    accept = in_valid & in_ready;
  end

  // INMODE[0] stays 0 so the A2 path is used; INMODE[1] gates A, [2] enables D, [3] subtracts.
  always_comb begin
    im_dec = IM_IDLE;
    case (in_op)
      3'd0:    im_dec = 4'b0100;
      3'd1:    im_dec = 4'b1100;
      3'd2:    im_dec = 4'b0000;
      3'd3:    im_dec = 4'b0110;
      3'd4:    im_dec = 4'b1000;
      default: im_dec = IM_IDLE;
    endcase
  end

  assign reserved = in_op[2] & in_op[1];
  assign im_in    = accept ? im_dec : IM_IDLE;
  assign a_in     = accept ? in_a : '0;
  assign d_in     = accept ? in_d : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_en  <= 1'b0;
      rst_q  <= 1'b1;
      err_op <= 1'b0;
    end else begin
      ce_en <= 1'b1;
      rst_q <= (next_state == ST_FLUSHING);
      if (flush)                    err_op <= 1'b0;
      else if (accept && reserved)  err_op <= 1'b1;
    end
  end

  assign dp_cea1 = ce_en & ~hold;
  assign dp_cea2 = ce_en & ~hold;
  assign dp_ced  = ce_en & ~hold;
  assign dp_cead = ce_en & ~hold;
  assign dp_rsta = rst_q;
  assign dp_rstd = rst_q;

  // Each skew line is a flat shift register, stage 0 in the low bits.
  generate
    if (A_SKEW == 0) begin : g_a_wire
      assign dp_a = a_in;
    end else begin : g_a_skew
      logic [A_SKEW*A_W-1:0] a_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     a_sr <= '0;
        else if (flush) a_sr <= '0;
        else if (!hold) a_sr <= (A_SKEW*A_W)'({a_sr, a_in});
      end
      assign dp_a = a_sr[A_SKEW*A_W-1 -: A_W];
    end

    if (D_SKEW == 0) begin : g_d_wire
      assign dp_d = d_in;
    end else begin : g_d_skew
      logic [D_SKEW*D_W-1:0] d_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     d_sr <= '0;
        else if (flush) d_sr <= '0;
        else if (!hold) d_sr <= (D_SKEW*D_W)'({d_sr, d_in});
      end
      assign dp_d = d_sr[D_SKEW*D_W-1 -: D_W];
    end

    if (LAT == 0) begin : g_im_wire
      assign dp_inmode = im_in;
    end else begin : g_im_sr
      logic [LAT*IM_W-1:0] im_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     im_sr <= {LAT{IM_IDLE}};
        else if (flush) im_sr <= {LAT{IM_IDLE}};
        else if (!hold) im_sr <= (LAT*IM_W)'({im_sr, im_in});
      end
      assign dp_inmode = im_sr[LAT*IM_W-1 -: IM_W];
    end

    if (RLAT == 0) begin : g_res_wire
      assign v_last = accept;
      assign t_last = accept ? in_tag : '0;
      assign v_any  = 1'b0;
    end else begin : g_res_sr
      logic [RLAT-1:0]       vld_sr;
      logic [RLAT*TAG_W-1:0] tag_sr;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_sr <= '0;
          tag_sr <= '0;
        end else if (flush) begin
          vld_sr <= '0;
          tag_sr <= '0;
        end else if (!hold) begin
          vld_sr <= RLAT'({vld_sr, accept});
          tag_sr <= (RLAT*TAG_W)'({tag_sr, in_tag});
        end
      end
      assign v_last = vld_sr[RLAT-1];
      assign t_last = tag_sr[RLAT*TAG_W-1 -: TAG_W];
      assign v_any  = |vld_sr;
    end
  endgenerate

  assign res_valid = v_last & ~hold & ~flush;
  assign res_tag   = t_last;
  assign busy      = v_any | (state == ST_FLUSHING);

endmodule
